// File: rtl/oled_spi_sink.sv
// Receiving end of the OLED serial link: oversamples SDIN/SCLK/DC/RES on clkX4,
// assembles MSB-first bytes tagged command/data, and queues them in a show-ahead FIFO.
module oled_spi_sink #(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic       clkX4,
    input  logic       rst,
    input  logic       SDIN,
    input  logic       SCLK,
    input  logic       DC,
    input  logic       RES,
    output logic [7:0] outData,
    output logic       outIsData,
    output logic       outValid,
    input  logic       outReady,
    output logic       overflow,
    output logic [7:0] frameErrCnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    logic          sclk_s1_q, sclk_s_q, sclk_prev_q;
    logic          sdin_s1_q, sdin_s_q;
    logic          dc_s1_q, dc_s_q;
    logic          res_s1_q, res_s_q;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    err_q, err_d;
    logic [6:0]    shift_q, shift_d;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic rise, push, abort, shift_en, pop, full, wr_en;

    // Two-flop synchronizers; sclk_prev tracks the synced SCLK every cycle,
    // so leaving HOLD with SCLK already high never looks like an edge.
    always_ff @(posedge clkX4 or negedge rst) begin
        if (!rst) begin
            sclk_s1_q <= 1'b0; sclk_s_q <= 1'b0; sclk_prev_q <= 1'b0;
            sdin_s1_q <= 1'b0; sdin_s_q <= 1'b0;
            dc_s1_q   <= 1'b0; dc_s_q   <= 1'b0;
            res_s1_q  <= 1'b1; res_s_q  <= 1'b1;
        end else begin
            sclk_s1_q <= SCLK; sclk_s_q <= sclk_s1_q; sclk_prev_q <= sclk_s_q;
            sdin_s1_q <= SDIN; sdin_s_q <= sdin_s1_q;
            dc_s1_q   <= DC;   dc_s_q   <= dc_s1_q;
            res_s1_q  <= RES;  res_s_q  <= res_s1_q;
        end
    end

    assign rise = sclk_s_q & ~sclk_prev_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        err_d     = err_q;
        push      = 1'b0;
        abort     = 1'b0;
        shift_en  = 1'b0;
        if (!res_s_q) begin
            state_d   = HOLD;
            bit_cnt_d = 3'd0;
            timer_d   = '0;
            abort     = (state_q == SHIFT);
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (rise) begin
                        shift_en  = 1'b1;
                        bit_cnt_d = 3'd1;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        timer_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            push      = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = IDLE;
                        end else begin
                            shift_en  = 1'b1;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (timer_q == TMAX) begin
                        abort     = 1'b1;
                        bit_cnt_d = 3'd0;
                        timer_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
        if (abort && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        shift_d = shift_en ? {shift_q[5:0], sdin_s_q} : shift_q;
    end

    // FIFO: a push into a full FIFO still lands when the head pops the same cycle.
    always_comb begin
        pop        = (count_q != '0) && outReady;
        full       = (count_q == FULL);
        wr_en      = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = {dc_s_q, shift_q, sdin_s_q};
    end

    always_ff @(posedge clkX4 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            timer_q    <= '0;
            err_q      <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage carries no reset; outputs are gated by outValid instead.
    always_ff @(posedge clkX4) begin
        shift_q <= shift_d;
        mem_q   <= mem_d;
    end

    assign outValid    = (count_q != '0);
    assign outData     = outValid ? mem_q[rd_ptr_q][7:0] : 8'd0;
    assign outIsData   = outValid ? mem_q[rd_ptr_q][8] : 1'b0;
    assign overflow    = overflow_q;
    assign frameErrCnt = err_q;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: table of bytes plus hand-written corner sequences.
module tb_oled_spi_sink;
    logic       clkX4 = 1'b0;
    logic       rst = 1'b0;
    logic       SDIN = 1'b0, SCLK = 1'b0, DC = 1'b0, RES = 1'b1;
    logic [7:0] outData;
    logic       outIsData, outValid;
    logic       outReady = 1'b0;
    logic       overflow;
    logic [7:0] frameErrCnt;

    int total = 0;
    int passed = 0;

    oled_spi_sink #(.FIFO_DEPTH(4), .IDLE_TIMEOUT(64)) dut (
        .clkX4(clkX4), .rst(rst), .SDIN(SDIN), .SCLK(SCLK), .DC(DC), .RES(RES),
        .outData(outData), .outIsData(outIsData), .outValid(outValid),
        .outReady(outReady), .overflow(overflow), .frameErrCnt(frameErrCnt)
    );

    always #5 clkX4 = ~clkX4;

    typedef struct {
        logic [7:0] din;
        logic       dc;
        logic [7:0] exp_data;
        logic       exp_is_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clkX4);
    endtask

    // Send the top n bits of b MSB-first, SCLK period 8 clkX4; SCLK ends high.
    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 0; i < n; i++) begin
            SDIN = b[7-i];
            DC   = dc;
            SCLK = 1'b0;
            cycles(4);
            SCLK = 1'b1;
            cycles(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
        cycles(2);
    endtask

    task automatic pop_check(input string name, input logic [7:0] eb, input logic edc);
        check({name, "_valid"}, outValid, 1);
        check({name, "_data"}, outData, eb);
        check({name, "_isdata"}, outIsData, edc);
        outReady = 1'b1;
        @(negedge clkX4);
        outReady = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'hAE, 1'b0, 8'hAE, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
        vecs[2] = '{8'h81, 1'b0, 8'h81, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h5A, 1'b0, 8'h5A, 1'b0};

        // Reset state
        cycles(3);
        check("rst_valid", outValid, 0);
        check("rst_data", outData, 0);
        check("rst_isdata", outIsData, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", frameErrCnt, 0);
        rst = 1'b1;
        cycles(3);

        // Test 1: 0xAE command byte with exact output latency
        send_bits(8'hAE, 1'b0, 7);
        SDIN = 1'b0;
        SCLK = 1'b0;
        cycles(4);
        SCLK = 1'b1;
        cycles(1);
        check("t1_lat1", outValid, 0);
        cycles(1);
        check("t1_lat2", outValid, 0);
        cycles(1);
        check("t1_lat3", outValid, 1);
        pop_check("t1", 8'hAE, 1'b0);
        check("t1_empty", outValid, 0);

        // Table-driven single bytes
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].din, vecs[i].dc);
            pop_check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_is_data);
            check($sformatf("vec%0d_empty", i), outValid, 0);
        end

        // Test 3: full FIFO, pop in the same cycle the 5th byte is pushed
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b0);
        send_byte(8'h40, 1'b1);
        check("t3_head", outData, 8'h10);
        send_bits(8'h50, 1'b0, 7);
        SDIN = 1'b0;
        SCLK = 1'b0;
        cycles(4);
        SCLK = 1'b1;
        cycles(2);
        outReady = 1'b1;
        cycles(1);
        outReady = 1'b0;
        cycles(2);
        check("t3_ovf", overflow, 0);
        pop_check("t3_p0", 8'h20, 1'b1);
        pop_check("t3_p1", 8'h30, 1'b0);
        pop_check("t3_p2", 8'h40, 1'b1);
        pop_check("t3_p3", 8'h50, 1'b0);
        check("t3_empty", outValid, 0);

        // Test 4: partial byte aborted by idle timeout
        send_bits(8'hE0, 1'b1, 3);
        cycles(30);
        check("t4_err_early", frameErrCnt, 0);
        cycles(50);
        check("t4_err", frameErrCnt, 1);
        check("t4_nothing", outValid, 0);
        send_byte(8'h3C, 1'b1);
        pop_check("t4", 8'h3C, 1'b1);
        check("t4_empty", outValid, 0);

        // Test 5: RES mid-byte keeps queued bytes
        send_byte(8'h77, 1'b0);
        send_bits(8'hF8, 1'b1, 5);
        RES = 1'b0;
        cycles(8);
        check("t5_err", frameErrCnt, 2);
        check("t5_kept", outData, 8'h77);
        RES = 1'b1;
        cycles(8);
        send_byte(8'h81, 1'b1);
        check("t5_err_hold", frameErrCnt, 2);
        pop_check("t5_p0", 8'h77, 1'b0);
        pop_check("t5_p1", 8'h81, 1'b1);
        check("t5_empty", outValid, 0);

        // Test 2: overflow on a 5th byte with no consumer
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        check("t2_ovf_before", overflow, 0);
        send_byte(8'h11, 1'b1);
        check("t2_ovf", overflow, 1);
        check("t2_head", outData, 8'hA5);
        pop_check("t2_p0", 8'hA5, 1'b1);
        pop_check("t2_p1", 8'h5A, 1'b1);
        check("t2_ovf_sticky", overflow, 1);

        // Test 6: async reset mid-byte with two bytes queued
        send_bits(8'h0F, 1'b0, 4);
        #2;
        rst = 1'b0;
        #1;
        check("t6_valid", outValid, 0);
        check("t6_data", outData, 0);
        check("t6_isdata", outIsData, 0);
        check("t6_ovf", overflow, 0);
        check("t6_err", frameErrCnt, 0);
        SCLK = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(3);
        check("t6_idle", outValid, 0);
        send_byte(8'hC3, 1'b1);
        pop_check("t6", 8'hC3, 1'b1);
        check("t6_empty", outValid, 0);
        check("t6_err_after", frameErrCnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
